// File: rtl/aud_player.sv
// aud_player: I2S-style DAC transmitter that streams mono PCM samples from SRAM,
// sending each sample on both left and right channels, with start/pause/stop control.
module aud_player #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 20
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_daclrck,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic [ADDR_W-1:0] i_end_addr,
    input  logic [DATA_W-1:0] i_sram_data,
    output logic [ADDR_W-1:0] o_address,
    output logic              o_aud_dacdat,
    output logic              o_PLAY_finish
);
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        StIdle,
        StWaitL,
        StSendL,
        StWaitR,
        StSendR,
        StPaused
    } state_e;

    state_e              r_state, w_state_d;
    logic                r_lrc;
    logic [DATA_W-1:0]   r_shreg, w_shreg_d;
    logic [CNT_W-1:0]    r_cnt, w_cnt_d;
    logic                r_pause, w_pause_d;
    logic [ADDR_W-1:0]   r_end, w_end_d;
    logic [ADDR_W-1:0]   r_address, w_address_d;
    logic                r_dacdat, w_dacdat_d;
    logic                r_finish, w_finish_d;

    logic w_fall, w_rise, w_last_bit, w_at_end, w_pause_eff, w_stop;

    assign w_fall      = r_lrc & ~i_daclrck;
    assign w_rise      = ~r_lrc & i_daclrck;
    assign w_last_bit  = (r_cnt == CNT_W'(DATA_W));
    assign w_at_end    = (r_address == r_end);
    assign w_stop      = i_stop && (r_state != StIdle);
    // Pause request including any toggle arriving this cycle.
    assign w_pause_eff = r_pause ^ i_pause;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_lrc     <= 1'b0;
            r_shreg   <= '0;
            r_cnt     <= '0;
            r_pause   <= 1'b0;
            r_end     <= '0;
            r_address <= '0;
            r_dacdat  <= 1'b0;
            r_finish  <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_lrc     <= i_daclrck;
            r_shreg   <= w_shreg_d;
            r_cnt     <= w_cnt_d;
            r_pause   <= w_pause_d;
            r_end     <= w_end_d;
            r_address <= w_address_d;
            r_dacdat  <= w_dacdat_d;
            r_finish  <= w_finish_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        if (w_stop) begin
            w_state_d = StIdle;
        end else begin
            unique case (r_state)
                StIdle:   if (i_start) w_state_d = StWaitL;
                StWaitL:  if (w_fall) w_state_d = StSendL;
                StSendL:  if (w_last_bit) w_state_d = StWaitR;
                StWaitR:  if (w_rise) w_state_d = StSendR;
                StSendR: begin
                    if (w_last_bit) begin
                        if (w_at_end) begin
                            w_state_d = StIdle;
                        end else if (w_pause_eff) begin
                            w_state_d = StPaused;
                        end else begin
                            w_state_d = StWaitL;
                        end
                    end
                end
                StPaused: if (i_pause) w_state_d = StWaitL;
                default:  w_state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        w_shreg_d   = r_shreg;
        w_cnt_d     = r_cnt;
        w_pause_d   = r_pause;
        w_end_d     = r_end;
        w_address_d = r_address;
        w_dacdat_d  = 1'b0;
        w_finish_d  = 1'b0;
        if (w_stop) begin
            w_address_d = '0;
            w_pause_d   = 1'b0;
            w_cnt_d     = '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        w_end_d     = i_end_addr;
                        w_address_d = '0;
                        w_pause_d   = 1'b0;
                    end
                end
                StWaitL, StWaitR: begin
                    w_pause_d = w_pause_eff;
                    if ((r_state == StWaitL && w_fall) || (r_state == StWaitR && w_rise)) begin
                        w_shreg_d  = i_sram_data;
                        w_dacdat_d = i_sram_data[DATA_W-1];
                        w_cnt_d    = CNT_W'(1);
                    end
                end
                StSendL, StSendR: begin
                    w_pause_d = w_pause_eff;
                    if (!w_last_bit) begin
                        w_dacdat_d = r_shreg[DATA_W-2];
                        w_shreg_d  = r_shreg << 1;
                        w_cnt_d    = r_cnt + CNT_W'(1);
                    end else begin
                        w_cnt_d = '0;
                        // Frame boundary: advance address, finish, or consume the pause request.
                        if (r_state == StSendR) begin
                            if (w_at_end) begin
                                w_finish_d  = 1'b1;
                                w_address_d = '0;
                            end else begin
                                w_address_d = r_address + ADDR_W'(1);
                                if (w_pause_eff) w_pause_d = 1'b0;
                            end
                        end
                    end
                end
                StPaused: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign o_address     = r_address;
    assign o_aud_dacdat  = r_dacdat;
    assign o_PLAY_finish = r_finish;

endmodule
